// File: rtl/icache_direct_pkg.sv
`default_nettype none
// ============================================================================
// Module : icache_direct_pkg
// Brief  : Shared types and field widths for the direct-mapped instruction
//          cache. Holds the frame layout, the controller FSM state encoding
//          and the address field widths for the default 16-frame geometry.
// Rev    : 1.0  initial release
// ============================================================================
package icache_direct_pkg;

  localparam int ICACHE_WORD_W   = 32;
  localparam int ICACHE_DEF_SETS = 16;

  // Address fields for the default geometry.
  localparam int ICACHE_OFF_W = 2;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_DEF_SETS);
  localparam int ICACHE_TAG_W = ICACHE_WORD_W - ICACHE_OFF_W - ICACHE_IDX_W;

  // Widest tag any legal geometry needs (SETS = 2 leaves 29 tag bits).
  // Frames store the tag zero-extended to this width so one frame type
  // serves every SETS value; unused upper bits are constant zero.
  localparam int ICACHE_TAG_MAX_W = ICACHE_WORD_W - ICACHE_OFF_W - 1;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    logic [ICACHE_WORD_W-1:0]    data;
  } icache_frame_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// Module : icache_direct
// Brief  : Direct-mapped, one-word-per-frame instruction cache. Hits are
//          served combinationally; a miss runs one single-word fill through
//          the iREN/iaddr/iwait/iload handshake and forwards the fill word in
//          the completing cycle. Saturating hit/miss counters.
// Ports  : CLK, nRST (sync, active-low)
//          imemREN, imemaddr        - datapath fetch request
//          ihit, imemload           - fetch response
//          iREN, iaddr, iwait, iload - memory controller fill port
//          hit_count, miss_count    - performance counters
// Rev    : 1.0  initial release
// ============================================================================
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);

  icache_state_t            state_q, state_d;
  icache_frame_t            frames_q [SETS];
  logic [29:0]              miss_word_q;   // word address of the pending fill
  logic [CNT_W-1:0]         hit_cnt_q;
  logic [CNT_W-1:0]         miss_cnt_q;

  logic [IDX_W-1:0]            w_idx;
  logic [ICACHE_TAG_MAX_W-1:0] w_tag;
  logic [IDX_W-1:0]            w_fill_idx;
  logic [ICACHE_TAG_MAX_W-1:0] w_fill_tag;
  logic                        w_lookup_hit;
  logic                        w_miss_start;
  logic                        w_fill_we;
  logic                        w_hit_evt;

  // Byte offset never selects anything in a one-word frame.
  logic unused_offset_bits;
  assign unused_offset_bits = ^imemaddr[1:0];

  assign w_idx      = imemaddr[2+IDX_W-1:2];
  assign w_tag      = ICACHE_TAG_MAX_W'(imemaddr[31:2+IDX_W]);
  assign w_fill_idx = miss_word_q[IDX_W-1:0];
  assign w_fill_tag = ICACHE_TAG_MAX_W'(miss_word_q[29:IDX_W]);

  assign w_lookup_hit = imemREN & frames_q[w_idx].valid &
                        (frames_q[w_idx].tag == w_tag);

  always_comb begin
    state_d      = state_q;
    ihit         = 1'b0;
    imemload     = '0;
    iREN         = 1'b0;
    iaddr        = '0;
    w_miss_start = 1'b0;
    w_fill_we    = 1'b0;
    w_hit_evt    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_lookup_hit) begin
          ihit      = 1'b1;
          imemload  = frames_q[w_idx].data;
          w_hit_evt = 1'b1;
        end else if (imemREN) begin
          w_miss_start = 1'b1;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_word_q, 2'b00};
        if (!iwait) begin
          w_fill_we = 1'b1;
          state_d   = IDLE;
          // Forward only when the datapath still wants the filled word;
          // any other address is looked up normally next cycle.
          if (imemREN && (imemaddr[31:2] == miss_word_q)) begin
            ihit     = 1'b1;
            imemload = iload;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_word_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_miss_start) begin
        miss_word_q <= imemaddr[31:2];
      end
    end
  end

  // Only valid bits are reset; tag/data are don't-care while invalid. A
  // reset during FETCH suppresses the write, discarding the pending fill.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        frames_q[i].valid <= 1'b0;
      end
    end else if (w_fill_we) begin
      frames_q[w_fill_idx] <= '{valid: 1'b1, tag: w_fill_tag, data: iload};
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_cnt_q <= '0;
    end else if (w_hit_evt && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_q <= hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      miss_cnt_q <= '0;
    end else if (w_miss_start && (miss_cnt_q != {CNT_W{1'b1}})) begin
      miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
`default_nettype wire
